// File: rtl/latch_sampler.sv
// Samples a level-sensitive latch bus: waits for the writer's window to close,
// lets the synchronised word settle, then offers it on a valid/ready handshake.
module latch_sampler #(
    parameter int WIDTH         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             open,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             overrun_clr
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        OFFER
    } state_t;

    logic [SYNC_STAGES-1:0]            open_sync_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] data_sync_q;
    logic                              open_s_d_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             overrun_q, overrun_d;

    logic             open_s;
    logic [WIDTH-1:0] data_s;
    logic             fall;
    logic             xfer;
    logic             take_fall;

    assign open_s    = open_sync_q[SYNC_STAGES-1];
    assign data_s    = data_sync_q[SYNC_STAGES-1];
    assign fall      = !open_s && open_s_d_q;
    assign out_valid = (state_q == OFFER);
    assign xfer      = out_valid && out_ready;
    assign out_data  = out_data_q;
    assign overrun   = overrun_q;

    // A close event is accepted from IDLE, or from OFFER when the pending word leaves on the same edge.
    assign take_fall = fall && ((state_q == IDLE) || xfer);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            open_sync_q <= '1;
            data_sync_q <= '0;
            open_s_d_q  <= 1'b1;
            state_q     <= IDLE;
            count_q     <= '0;
            cand_q      <= '0;
            out_data_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            open_sync_q <= {open_sync_q[SYNC_STAGES-2:0], open};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], d_in};
            open_s_d_q  <= open_s;
            state_q     <= state_d;
            count_q     <= count_d;
            cand_q      <= cand_d;
            out_data_q  <= out_data_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        cand_d     = cand_q;
        out_data_d = out_data_q;
        overrun_d  = overrun_q && !overrun_clr;

        case (state_q)
            IDLE: begin
            end
            SETTLE: begin
                if (open_s) begin
                    state_d = IDLE;
                end else if (data_s != cand_q) begin
                    cand_d  = data_s;
                    count_d = CNT_ONE;
                end else if (count_q + CNT_ONE == CNT_LAST) begin
                    out_data_d = cand_q;
                    state_d    = OFFER;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            OFFER: begin
                if (xfer) begin
                    state_d = IDLE;
                end else if (fall) begin
                    // Set wins over a simultaneous clear; the offered word is kept.
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take_fall) begin
            cand_d  = data_s;
            count_d = CNT_ONE;
            if (STABLE_CYCLES == 1) begin
                out_data_d = data_s;
                state_d    = OFFER;
            end else begin
                state_d = SETTLE;
            end
        end
    end

endmodule
